alu_issue_queue: RTL and testbench

//  Upstream command stage for the alu block: buffers operand/opcode commands from a

---
 rtl/alu_issue_queue.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_issue_queue                                               |
// | Purpose  : Command stage in front of the alu block. Buffers operand/     |
// |            opcode commands from a valid/ready producer, issues at most   |
// |            one command per cycle onto the alu a/b/o inputs and captures  |
// |            the returning result/carry/borrow into a result buffer that   |
// |            is drained by valid/ready. Issue is credit-based, so a result |
// |            always has a buffer slot when it returns. Strictly in order.  |
// | Ports    : clk, rst_n          clock / asynchronous active-low reset    |
// |            i_in_valid/o_in_ready, i_in_a, i_in_b, i_in_op  command in    |
// |            o_alu_a, o_alu_b, o_alu_o                       to alu        |
// |            i_alu_result, i_alu_c, i_alu_bo                 from alu      |
// |            o_out_valid/i_out_ready, o_out_result, o_out_c, o_out_bo      |
// |                                                            result out    |
// |            o_busy  any command queued, in flight or buffered             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module alu_issue_queue #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 2,
  parameter int DEPTH   = 4,
  parameter int RDEPTH  = 2,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // command input
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic [OPW-1:0]   i_in_op,
  // alu interface
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [OPW-1:0]   o_alu_o,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_c,
  input  logic             i_alu_bo,
  // result output
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_result,
  output logic             o_out_c,
  output logic             o_out_bo,
  // status
  output logic             o_busy
);

  // ------------------------------------------------------------------------
  // Derived widths and constants
  // ------------------------------------------------------------------------
  localparam int c_aw  = $clog2(DEPTH);
  localparam int c_cw  = $clog2(DEPTH) + 1;
  localparam int c_raw = $clog2(RDEPTH);
  localparam int c_rcw = $clog2(RDEPTH) + 1;
  // Credit arithmetic must hold rcnt + inflight and RDEPTH + 1 without wrap.
  localparam int c_kw  = $clog2(RDEPTH + ALU_LAT + 1) + 1;
  localparam int c_ew  = 2 * WIDTH + OPW;
  localparam int c_rw  = WIDTH + 2;

  localparam logic [c_cw-1:0]  c_depth      = c_cw'(DEPTH);
  localparam logic [c_rcw-1:0] c_rdepth_cnt = c_rcw'(RDEPTH);
  localparam logic [c_kw-1:0]  c_rdepth_crd = c_kw'(RDEPTH);

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [c_ew-1:0]    r_cmd_mem [DEPTH];
  logic [c_aw-1:0]    r_cmd_wptr;
  logic [c_aw-1:0]    r_cmd_rptr;
  logic [c_cw-1:0]    r_cmd_cnt;
  logic               r_in_ready;

  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [OPW-1:0]     r_alu_o;

  // One valid bit per outstanding alu operation; bit 0 is set on issue.
  logic [ALU_LAT-1:0] r_pipe;

  logic [c_rw-1:0]    r_res_mem [RDEPTH];
  logic [c_raw-1:0]   r_res_wptr;
  logic [c_raw-1:0]   r_res_rptr;
  logic [c_rcw-1:0]   r_res_cnt;

  // ------------------------------------------------------------------------
  // Combinational control
  // ------------------------------------------------------------------------
  logic               w_push;
  logic               w_issue;
  logic               w_capture;
  logic               w_drain;
  logic               w_credit_ok;
  logic [c_cw-1:0]    w_cmd_cnt_nxt;
  logic [c_kw-1:0]    w_inflight;
  logic [c_kw-1:0]    w_used;
  logic [c_kw-1:0]    w_limit;
  logic [c_rw-1:0]    w_res_head;

  // in_ready is a register, so a full FIFO refuses a push even on an edge
  // where the head is issued.
  assign w_push    = i_in_valid && r_in_ready;
  assign w_drain   = (r_res_cnt != '0) && i_out_ready;
  assign w_capture = r_pipe[ALU_LAT-1];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      w_inflight = w_inflight + c_kw'(r_pipe[i]);
    end
  end

  // Every buffered or in-flight result owns a result-buffer slot. A slot
  // drained on this edge is free again before any newly issued command can
  // return (ALU_LAT >= 1), so it is credited immediately; this is what lets
  // RDEPTH = ALU_LAT + 1 sustain one command per cycle.
  assign w_used      = c_kw'(r_res_cnt) + w_inflight;
  assign w_limit     = c_rdepth_crd + c_kw'(w_drain);
  assign w_credit_ok = (w_used < w_limit);
  assign w_issue     = (r_cmd_cnt != '0) && w_credit_ok;

  assign w_cmd_cnt_nxt = r_cmd_cnt + c_cw'(w_push) - c_cw'(w_issue);

  // ------------------------------------------------------------------------
  // Command FIFO storage (data only, no reset needed)
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_mem[r_cmd_wptr] <= {i_in_a, i_in_b, i_in_op};
    end
  end

  // ------------------------------------------------------------------------
  // Command FIFO control and alu operand registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_wptr <= '0;
      r_cmd_rptr <= '0;
      r_cmd_cnt  <= '0;
      r_in_ready <= 1'b1;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_o    <= '0;
    end else begin
      if (w_push) begin
        r_cmd_wptr <= r_cmd_wptr + c_aw'(1);
      end
      if (w_issue) begin
        r_cmd_rptr                  <= r_cmd_rptr + c_aw'(1);
        {r_alu_a, r_alu_b, r_alu_o} <= r_cmd_mem[r_cmd_rptr];
      end
      r_cmd_cnt  <= w_cmd_cnt_nxt;
      r_in_ready <= (w_cmd_cnt_nxt < c_depth);
    end
  end

  // ------------------------------------------------------------------------
  // In-flight tracking: the issue bit walks ALU_LAT stages; when it sits in
  // the last stage the alu result is valid at that edge.
  // ------------------------------------------------------------------------
  generate
    if (ALU_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= w_issue;
        end
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= {r_pipe[ALU_LAT-2:0], w_issue};
        end
      end
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Result buffer. Storage is cleared on reset so the combinational head
  // outputs read zero until the first result lands.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RDEPTH; i++) begin
        r_res_mem[i] <= '0;
      end
      r_res_wptr <= '0;
      r_res_rptr <= '0;
      r_res_cnt  <= '0;
    end else begin
      if (w_capture) begin
        r_res_mem[r_res_wptr] <= {i_alu_result, i_alu_c, i_alu_bo};
        r_res_wptr            <= r_res_wptr + c_raw'(1);
      end
      if (w_drain) begin
        r_res_rptr <= r_res_rptr + c_raw'(1);
      end
      r_res_cnt <= r_res_cnt + c_rcw'(w_capture) - c_rcw'(w_drain);
    end
  end

  assign w_res_head = r_res_mem[r_res_rptr];

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign o_in_ready   = r_in_ready;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_o      = r_alu_o;
  assign o_out_valid  = (r_res_cnt != '0);
  assign o_out_result = w_res_head[c_rw-1:2];
  assign o_out_c      = w_res_head[1];
  assign o_out_bo     = w_res_head[0];
  assign o_busy       = (r_cmd_cnt != '0) || (r_pipe != '0) || (r_res_cnt != '0);

  // ------------------------------------------------------------------------
  // Safety properties
  // ------------------------------------------------------------------------
  a_capture_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    w_capture |-> (r_res_cnt < c_rdepth_cnt));

  a_issue_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
    w_issue |-> (r_cmd_cnt != '0));

  a_drain_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
    w_drain |-> (r_res_cnt != '0));

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_issue_queue                                            |
// | Purpose  : Self-checking bench for alu_issue_queue. Two instances:       |
// |            index 0 with ALU_LAT=1/RDEPTH=2 (directed + random) and       |
// |            index 1 with ALU_LAT=3/RDEPTH=4 (random). Each has a          |
// |            behavioural alu with the matching latency; a monitor keeps a  |
// |            queue of expected results per instance.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tb_alu_issue_queue;

  localparam int          c_n      = 1000;
  localparam logic [1:0]  c_op_add = 2'd0;
  localparam logic [1:0]  c_op_sub = 2'd1;

  logic       clk;
  logic       rst_n;

  logic       in_valid   [2];
  logic       in_ready   [2];
  logic [7:0] in_a       [2];
  logic [7:0] in_b       [2];
  logic [1:0] in_op      [2];
  logic [7:0] alu_a      [2];
  logic [7:0] alu_b      [2];
  logic [1:0] alu_o      [2];
  logic [7:0] alu_result [2];
  logic       alu_c      [2];
  logic       alu_bo     [2];
  logic       out_valid  [2];
  logic       out_ready  [2];
  logic [7:0] out_result [2];
  logic       out_c      [2];
  logic       out_bo     [2];
  logic       busy       [2];

  int         errors;
  int         checks;
  logic [9:0] exp_q [2][$];
  logic [9:0] mon_e;

  // Reference alu: 0 add (carry), 1 sub (borrow), 2 and, 3 xor.
  // Packed as {result, c, bo}.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
    logic [8:0] s;
    case (op)
      2'd0:    begin s = {1'b0, a} + {1'b0, b}; return {s[7:0], s[8], 1'b0}; end
      2'd1:    begin s = {1'b0, a} - {1'b0, b}; return {s[7:0], 1'b0, s[8]}; end
      2'd2:    return {a & b, 2'b00};
      default: return {a ^ b, 2'b00};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  // DUTs and behavioural alus
  // ------------------------------------------------------------------------
  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_dut
      localparam int LAT = (k == 0) ? 1 : 3;
      localparam int RD  = (k == 0) ? 2 : 4;

      logic [9:0] f_now;
      logic [9:0] stg [1:3];

      assign f_now = alu_f(alu_a[k], alu_b[k], alu_o[k]);

      always @(posedge clk) begin
        stg[1] <= f_now;
        stg[2] <= stg[1];
        stg[3] <= stg[2];
      end

      if (LAT == 1) begin : g_comb
        assign {alu_result[k], alu_c[k], alu_bo[k]} = f_now;
      end else begin : g_reg
        assign {alu_result[k], alu_c[k], alu_bo[k]} = stg[LAT-1];
      end

      alu_issue_queue #(
        .WIDTH   (8),
        .OPW     (2),
        .DEPTH   (4),
        .RDEPTH  (RD),
        .ALU_LAT (LAT)
      ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid[k]),
        .o_in_ready   (in_ready[k]),
        .i_in_a       (in_a[k]),
        .i_in_b       (in_b[k]),
        .i_in_op      (in_op[k]),
        .o_alu_a      (alu_a[k]),
        .o_alu_b      (alu_b[k]),
        .o_alu_o      (alu_o[k]),
        .i_alu_result (alu_result[k]),
        .i_alu_c      (alu_c[k]),
        .i_alu_bo     (alu_bo[k]),
        .o_out_valid  (out_valid[k]),
        .i_out_ready  (out_ready[k]),
        .o_out_result (out_result[k]),
        .o_out_c      (out_c[k]),
        .o_out_bo     (out_bo[k]),
        .o_busy       (busy[k])
      );
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Monitor / scoreboard: mid-cycle, values are those seen by the next edge.
  // ------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) exp_q[m].delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (in_valid[m] && in_ready[m])
          exp_q[m].push_back(alu_f(in_a[m], in_b[m], in_op[m]));
        if (out_valid[m] && out_ready[m]) begin
          if (exp_q[m].size() == 0) begin
            chk($sformatf("sb_unexpected_dut%0d", m), 32'(out_valid[m]), 32'd0);
          end else begin
            mon_e = exp_q[m].pop_front();
            chk($sformatf("sb_result_dut%0d", m),
                32'({out_result[m], out_c[m], out_bo[m]}), 32'(mon_e));
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  logic [7:0] fa [6];
  logic [7:0] fb [6];
  logic [1:0] fo [6];
  int         sent [2];
  int         cyc;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_a[i]      = '0;
      in_b[i]      = '0;
      in_op[i]     = '0;
      out_ready[i] = 1'b1;
    end
    fa = '{8'hFF, 8'h12, 8'h34, 8'hA5, 8'h80, 8'h3C};
    fb = '{8'h01, 8'h05, 8'h0F, 8'h5A, 8'h80, 8'hC3};
    fo = '{2'd0,  2'd1,  2'd2,  2'd3,  2'd0,  2'd1};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid",  32'(out_valid[0]),  32'd0);
    chk("rst_busy",       32'(busy[0]),       32'd0);
    chk("rst_alu_a",      32'(alu_a[0]),      32'd0);
    chk("rst_out_result", 32'(out_result[0]), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready[0]), 32'd1);

    // ---- single command latency: 0F + 01 ----
    in_valid[0] = 1'b1; in_a[0] = 8'h0F; in_b[0] = 8'h01; in_op[0] = c_op_add;
    step();                                  // push
    in_valid[0] = 1'b0;
    chk("lat_c1_valid", 32'(out_valid[0]), 32'd0);
    step();                                  // issue
    chk("lat_c2_valid", 32'(out_valid[0]), 32'd0);
    chk("lat_issue_a",  32'(alu_a[0]),     32'h0F);
    step();                                  // capture
    chk("lat_c3_valid", 32'(out_valid[0]),  32'd1);
    chk("lat_result",   32'(out_result[0]), 32'h10);
    chk("lat_carry",    32'(out_c[0]),      32'd0);
    chk("lat_busy",     32'(busy[0]),       32'd1);
    step();                                  // pop
    chk("lat_popped",   32'(out_valid[0]),  32'd0);
    chk("lat_busy_off", 32'(busy[0]),       32'd0);

    // ---- fill with the consumer stalled ----
    out_ready[0] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid[0] = 1'b1; in_a[0] = fa[j]; in_b[0] = fb[j]; in_op[0] = fo[j];
      chk($sformatf("fill_ready%0d", j), 32'(in_ready[0]), 32'd1);
      step();
    end
    chk("fill_full", 32'(in_ready[0]), 32'd0);
    // Seventh command (00 - 01) waits at the full FIFO.
    in_a[0] = 8'h00; in_b[0] = 8'h01; in_op[0] = c_op_sub;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("full_hold_ready", 32'(in_ready[0]), 32'd0);
      chk("full_alu_stable", 32'(alu_a[0]),    32'(fa[1]));
    end
    chk("fill_head_valid",  32'(out_valid[0]),  32'd1);
    chk("fill_head_result", 32'(out_result[0]), 32'h00);
    chk("fill_head_carry",  32'(out_c[0]),      32'd1);

    // ---- drain: one result per cycle ----
    out_ready[0] = 1'b1;
    chk("drain_ready_full", 32'(in_ready[0]), 32'd0);
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("drain_valid%0d", j), 32'(out_valid[0]), 32'd1);
      if (j == 6) begin
        chk("borrow_result", 32'(out_result[0]), 32'hFF);
        chk("borrow_bo",     32'(out_bo[0]),     32'd1);
      end
      step();
      if (j == 0) chk("ready_after_issue", 32'(in_ready[0]), 32'd1);
      if (j == 1) in_valid[0] = 1'b0;        // seventh command accepted
    end
    chk("drain_empty", 32'(out_valid[0]), 32'd0);

    // ---- reset in the middle of traffic ----
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1; in_b[0] = 8'h01; in_op[0] = c_op_add;
    in_a[0] = 8'h55; step();
    in_a[0] = 8'h66; step();
    in_a[0] = 8'h77; step();
    in_valid[0] = 1'b0;
    chk("pre_rst_busy",  32'(busy[0]),  32'd1);
    chk("pre_rst_alu_a", 32'(alu_a[0]), 32'h66);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_busy",  32'(busy[0]),      32'd0);
    chk("mid_rst_alu_a", 32'(alu_a[0]),     32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(in_ready[0]), 32'd1);
    out_ready[0] = 1'b1;
    repeat (6) step();
    chk("post_rst_no_stale", 32'(out_valid[0]), 32'd0);
    chk("post_rst_idle",     32'(busy[0]),      32'd0);

    // ---- randomized traffic on both instances ----
    sent[0] = 0;
    sent[1] = 0;
    cyc     = 0;
    while ((sent[0] < c_n || sent[1] < c_n) && cyc < 30000) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i]  = (sent[i] < c_n) && ($urandom_range(1, 0) == 1);
        in_a[i]      = 8'($urandom);
        in_b[i]      = 8'($urandom);
        in_op[i]     = 2'($urandom);
        out_ready[i] = ($urandom_range(1, 0) == 1);
      end
      for (int i = 0; i < 2; i++)
        if (in_valid[i] && in_ready[i]) sent[i]++;
      step();
      cyc++;
    end
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    chk("rand_sent_dut0", 32'(sent[0]), 32'(c_n));
    chk("rand_sent_dut1", 32'(sent[1]), 32'(c_n));

    cyc = 0;
    while ((busy[0] || busy[1]) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("rand_idle_dut0",    32'(busy[0]),          32'd0);
    chk("rand_idle_dut1",    32'(busy[1]),          32'd0);
    chk("rand_pending_dut0", 32'(exp_q[0].size()),  32'd0);
    chk("rand_pending_dut1", 32'(exp_q[1].size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
